dac_interleave: RTL

Upstream feeder for the DAC output driver. Accepts two independent 14-bit two's-complement sample streams (CH A, CH B) over valid/ready handshakes and buffers each in a small FIFO. Time-multiplexes them onto the single 14-bit DAC bus with active-low write strobe and channel select. Runs on dac_clk_i at 2x the per-channel sample rate, so one A slot plus one B slot forms one sample pair.

---
 rtl/dac_interleave.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/dac_interleave.sv
// dac_interleave
//   Upstream feeder for the DAC output driver. Two independent sample
//   streams (CH A, CH B) arrive over valid/ready handshakes. Each stream is
//   buffered in a small FIFO. The streams are then time-multiplexed onto one
//   DAC bus at 2x the per-channel rate: one A slot plus one B slot forms a
//   sample pair.
//
//   Bus words are encoded as {s[DW-1], ~s[DW-2:0]}. The transform is its own
//   inverse, so the downstream driver recovers s. Encoded zero is 'h1FFF.
//
// Parameters
//   DW          sample width in bits
//   FIFO_DEPTH  per-channel FIFO depth (power of 2, >= 4)
//   START_LVL   fill level both FIFOs must reach before streaming starts
//
// Ports
//   dac_clk_i            DAC clock (2x per-channel sample rate)
//   dac_rstn_i           asynchronous active-low reset
//   en_i                 enable streaming
//   clr_i                one-cycle clear of the sticky underflow flags
//   pat_en_i             test-pattern select (only with DAC_TEST_PATTERN_EN)
//   cha_dat_i/vld/rdy    CH A sample stream, two's complement
//   chb_dat_i/vld/rdy    CH B sample stream, two's complement
//   dac_dat_o            encoded DAC bus word
//   dac_wrt_o            write strobe, active low
//   dac_sel_o            0 = CH A slot, 1 = CH B slot
//   run_o                high while pairs are being emitted
//   unf_a_o / unf_b_o    sticky per-channel underflow flags
//
// Build option
//   `define DAC_TEST_PATTERN_EN adds pat_en_i. While it is high, CH A carries
//   a ramp that steps once per pair and CH B carries the negated ramp. The
//   FIFOs are still popped so handshake timing is unchanged.

module dac_interleave #(
    parameter int unsigned DW         = 14,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned START_LVL  = 2
) (
    input  logic          dac_clk_i,
    input  logic          dac_rstn_i,
    input  logic          en_i,
    input  logic          clr_i,
`ifdef DAC_TEST_PATTERN_EN
    input  logic          pat_en_i,
`endif
    input  logic [DW-1:0] cha_dat_i,
    input  logic          cha_vld_i,
    output logic          cha_rdy_o,
    input  logic [DW-1:0] chb_dat_i,
    input  logic          chb_vld_i,
    output logic          chb_rdy_o,
    output logic [DW-1:0] dac_dat_o,
    output logic          dac_wrt_o,
    output logic          dac_sel_o,
    output logic          run_o,
    output logic          unf_a_o,
    output logic          unf_b_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] START_CNT = CW'(START_LVL);
    localparam logic [DW-1:0] ENC_ZERO  = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } state_t;

    state_t state;

    function automatic logic [DW-1:0] encode(input logic [DW-1:0] s);
        return {s[DW-1], ~s[DW-2:0]};
    endfunction

    // ------------------------------------------------------------------
    // CH A FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0] mem_a [FIFO_DEPTH];
    logic [AW-1:0] wp_a;
    logic [AW-1:0] rp_a;
    logic [CW-1:0] cnt_a;
    logic          push_a;
    logic          pop_a;
    logic          empty_a;
    logic [DW-1:0] head_a;

    // Ready looks at the registered count only. A push into a full FIFO is
    // therefore refused even when the slot pops in the same cycle.
    assign cha_rdy_o = (cnt_a != FULL_CNT);
    assign push_a    = cha_vld_i & cha_rdy_o;
    assign empty_a   = (cnt_a == '0);
    assign pop_a     = (state == SLOT_A) & ~empty_a;
    assign head_a    = mem_a[rp_a];

    always_ff @(posedge dac_clk_i) begin
        if (push_a) begin
            mem_a[wp_a] <= cha_dat_i;
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            wp_a  <= '0;
            rp_a  <= '0;
            cnt_a <= '0;
        end else begin
            if (push_a) begin
                wp_a <= wp_a + 1'b1;
            end
            if (pop_a) begin
                rp_a <= rp_a + 1'b1;
            end
            case ({push_a, pop_a})
                2'b10:   cnt_a <= cnt_a + 1'b1;
                2'b01:   cnt_a <= cnt_a - 1'b1;
                default: cnt_a <= cnt_a;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CH B FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0] mem_b [FIFO_DEPTH];
    logic [AW-1:0] wp_b;
    logic [AW-1:0] rp_b;
    logic [CW-1:0] cnt_b;
    logic          push_b;
    logic          pop_b;
    logic          empty_b;
    logic [DW-1:0] head_b;

    assign chb_rdy_o = (cnt_b != FULL_CNT);
    assign push_b    = chb_vld_i & chb_rdy_o;
    assign empty_b   = (cnt_b == '0);
    assign pop_b     = (state == SLOT_B) & ~empty_b;
    assign head_b    = mem_b[rp_b];

    always_ff @(posedge dac_clk_i) begin
        if (push_b) begin
            mem_b[wp_b] <= chb_dat_i;
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            wp_b  <= '0;
            rp_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push_b) begin
                wp_b <= wp_b + 1'b1;
            end
            if (pop_b) begin
                rp_b <= rp_b + 1'b1;
            end
            case ({push_b, pop_b})
                2'b10:   cnt_b <= cnt_b + 1'b1;
                2'b01:   cnt_b <= cnt_b - 1'b1;
                default: cnt_b <= cnt_b;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot sample selection
    // ------------------------------------------------------------------
    logic [DW-1:0] held_a;
    logic [DW-1:0] held_b;
    logic [DW-1:0] smp_a;
    logic [DW-1:0] smp_b;
    logic          unf_a_evt;
    logic          unf_b_evt;

`ifdef DAC_TEST_PATTERN_EN
    logic [DW-1:0] ramp;

    // The ramp restarts from zero each time streaming starts from IDLE.
    // It advances after the B slot, so both halves of a pair share a value.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            ramp <= '0;
        end else if (state == IDLE) begin
            ramp <= '0;
        end else if ((state == SLOT_B) && pat_en_i) begin
            ramp <= ramp + 1'b1;
        end
    end
`endif

    // On an empty FIFO the last real sample of that channel is repeated.
    always_comb begin
        smp_a     = empty_a ? held_a : head_a;
        smp_b     = empty_b ? held_b : head_b;
        unf_a_evt = (state == SLOT_A) & empty_a;
        unf_b_evt = (state == SLOT_B) & empty_b;
`ifdef DAC_TEST_PATTERN_EN
        if (pat_en_i) begin
            smp_a     = ramp;
            smp_b     = '0 - ramp;
            unf_a_evt = 1'b0;
            unf_b_evt = 1'b0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Slot FSM with registered bus outputs (one cycle after the slot)
    // ------------------------------------------------------------------
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state     <= IDLE;
            dac_dat_o <= ENC_ZERO;
            dac_wrt_o <= 1'b1;
            dac_sel_o <= 1'b0;
            run_o     <= 1'b0;
            held_a    <= '0;
            held_b    <= '0;
            unf_a_o   <= 1'b0;
            unf_b_o   <= 1'b0;
        end else begin
            // A new underflow in the same cycle as clr_i keeps its flag set.
            if (clr_i) begin
                unf_a_o <= 1'b0;
                unf_b_o <= 1'b0;
            end
            if (unf_a_evt) begin
                unf_a_o <= 1'b1;
            end
            if (unf_b_evt) begin
                unf_b_o <= 1'b1;
            end

            if (pop_a) begin
                held_a <= head_a;
            end
            if (pop_b) begin
                held_b <= head_b;
            end

            case (state)
                IDLE: begin
                    dac_wrt_o <= 1'b1;
                    run_o     <= 1'b0;
                    if (en_i && (cnt_a >= START_CNT) && (cnt_b >= START_CNT)) begin
                        state <= SLOT_A;
                    end
                end
                SLOT_A: begin
                    dac_dat_o <= encode(smp_a);
                    dac_sel_o <= 1'b0;
                    dac_wrt_o <= 1'b0;
                    run_o     <= 1'b1;
                    state     <= SLOT_B;
                end
                SLOT_B: begin
                    dac_dat_o <= encode(smp_b);
                    dac_sel_o <= 1'b1;
                    dac_wrt_o <= 1'b0;
                    run_o     <= 1'b1;
                    state     <= en_i ? SLOT_A : IDLE;
                end
                default: begin
                    dac_wrt_o <= 1'b1;
                    run_o     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
